// File: rtl/crc_frame_pkg.sv
// Shared CRC-16/CCITT-FALSE constants, FSM states and step function
// for the per-frame CRC append stage.
package crc_frame_pkg;

    localparam int CRC_W = 16;
    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        APPEND,
        DROP
    } crc_state_e;

    // MSB-first serial step, no reflection, no final XOR
    function automatic logic [CRC_W-1:0] crc16_step(
        input logic [CRC_W-1:0] crc,
        input logic             din,
        input logic [CRC_W-1:0] poly
    );
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/crc16_serial.sv
// Serial CRC register: optional reseed from INIT, then one step per
// enabled cycle.
module crc16_serial #(
    parameter logic [crc_frame_pkg::CRC_W-1:0] POLY = crc_frame_pkg::CRC_POLY,
    parameter logic [crc_frame_pkg::CRC_W-1:0] INIT = crc_frame_pkg::CRC_INIT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            init,
    input  logic                            en,
    input  logic                            din,
    output logic [crc_frame_pkg::CRC_W-1:0] crc
);
    import crc_frame_pkg::*;

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;

    // init folds the first bit into the seed in the same cycle
    always_comb begin
        crc_d = crc_q;
        if (en) begin
            crc_d = crc16_step(init ? INIT : crc_q, din, POLY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/crc_frame_append.sv
// Forwards one-hot serial frames with one cycle of latency and appends
// the frame's CRC-16 MSB first on the same channel.
module crc_frame_append #(
    parameter int                CRC_W    = crc_frame_pkg::CRC_W,
    parameter logic [CRC_W-1:0]  CRC_POLY = crc_frame_pkg::CRC_POLY,
    parameter logic [CRC_W-1:0]  CRC_INIT = crc_frame_pkg::CRC_INIT
) (
    input  logic             clk_out16x,
    input  logic             rst_n,
    input  logic             crc_valid,
    input  logic [7:0]       data_in_ch,
    input  logic [7:0]       vld_in_ch,
    input  logic             err_clr,
    output logic [7:0]       tx_data_ch,
    output logic [7:0]       tx_vld_ch,
    output logic [CRC_W-1:0] crc_out,
    output logic [15:0]      frame_len,
    output logic             crc_done,
    output logic             crc_busy,
    output logic             ovf,
    output logic             err_onehot
);
    import crc_frame_pkg::*;

    crc_state_e       state_q, state_d;
    logic [7:0]       ch_q, ch_d;
    logic [15:0]      len_q, len_d;
    logic [CRC_W-1:0] sr_q, sr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             vprev_q, vprev_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       tx_vld_q, tx_vld_d;
    logic [CRC_W-1:0] crc_out_q, crc_out_d;
    logic [15:0]      frame_len_q, frame_len_d;
    logic             crc_done_q, crc_done_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic             ovf_set, err_set;
    logic             crc_init, crc_en, crc_din;
    logic [CRC_W-1:0] crc_cur;

    crc16_serial #(
        .POLY (CRC_POLY),
        .INIT (CRC_INIT)
    ) u_crc (
        .clk   (clk_out16x),
        .rst_n (rst_n),
        .init  (crc_init),
        .en    (crc_en),
        .din   (crc_din),
        .crc   (crc_cur)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        len_d       = len_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        vprev_d     = crc_valid;
        tx_data_d   = '0;
        tx_vld_d    = '0;
        crc_out_d   = crc_out_q;
        frame_len_d = frame_len_q;
        crc_done_d  = 1'b0;
        ovf_set     = 1'b0;
        err_set     = 1'b0;
        crc_init    = 1'b0;
        crc_en      = 1'b0;
        crc_din     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (crc_valid) begin
                    if ($onehot(vld_in_ch)) begin
                        ch_d      = vld_in_ch;
                        crc_init  = 1'b1;
                        crc_en    = 1'b1;
                        crc_din   = |(data_in_ch & vld_in_ch);
                        len_d     = 16'd1;
                        tx_vld_d  = vld_in_ch;
                        tx_data_d = vld_in_ch & {8{crc_din}};
                        state_d   = DATA;
                    end else begin
                        err_set = 1'b1;
                        state_d = DROP;
                    end
                end
            end
            DATA: begin
                tx_vld_d = ch_q;
                if (crc_valid) begin
                    crc_en    = 1'b1;
                    crc_din   = |(data_in_ch & ch_q);
                    len_d     = (&len_q) ? len_q : len_q + 16'd1;
                    tx_data_d = ch_q & {8{crc_din}};
                    err_set   = (vld_in_ch != ch_q);
                end else begin
                    sr_d        = {crc_cur[CRC_W-2:0], 1'b0};
                    tx_data_d   = ch_q & {8{crc_cur[CRC_W-1]}};
                    crc_out_d   = crc_cur;
                    frame_len_d = len_q;
                    cnt_d       = 4'd1;
                    state_d     = APPEND;
                end
            end
            APPEND: begin
                tx_vld_d  = ch_q;
                tx_data_d = ch_q & {8{sr_q[CRC_W-1]}};
                sr_d      = {sr_q[CRC_W-2:0], 1'b0};
                cnt_d     = cnt_q + 4'd1;
                ovf_set   = crc_valid & ~vprev_q;
                if (cnt_q == 4'd15) begin
                    crc_done_d = 1'b1;
                    if (crc_valid) begin
                        ovf_set = 1'b1;
                        state_d = DROP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (!crc_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        ovf_d  = ovf_set | (ovf_q & ~err_clr);
        err_d  = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk_out16x or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            len_q       <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            vprev_q     <= 1'b0;
            tx_data_q   <= '0;
            tx_vld_q    <= '0;
            crc_out_q   <= '0;
            frame_len_q <= '0;
            crc_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            len_q       <= len_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            vprev_q     <= vprev_d;
            tx_data_q   <= tx_data_d;
            tx_vld_q    <= tx_vld_d;
            crc_out_q   <= crc_out_d;
            frame_len_q <= frame_len_d;
            crc_done_q  <= crc_done_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign tx_data_ch = tx_data_q;
    assign tx_vld_ch  = tx_vld_q;
    assign crc_out    = crc_out_q;
    assign frame_len  = frame_len_q;
    assign crc_done   = crc_done_q;
    assign crc_busy   = busy_q;
    assign ovf        = ovf_q;
    assign err_onehot = err_q;

endmodule

// File: tb/tb_crc_frame_append.sv
// Scoreboard bench for crc_frame_append: random and directed frames
// against a bit-list CRC-16/CCITT-FALSE reference.
module tb_crc_frame_append;

    logic        clk_out16x = 1'b0;
    logic        rst_n      = 1'b0;
    logic        crc_valid  = 1'b0;
    logic [7:0]  data_in_ch = '0;
    logic [7:0]  vld_in_ch  = '0;
    logic        err_clr    = 1'b0;
    logic [7:0]  tx_data_ch;
    logic [7:0]  tx_vld_ch;
    logic [15:0] crc_out;
    logic [15:0] frame_len;
    logic        crc_done;
    logic        crc_busy;
    logic        ovf;
    logic        err_onehot;

    crc_frame_append dut (
        .clk_out16x (clk_out16x),
        .rst_n      (rst_n),
        .crc_valid  (crc_valid),
        .data_in_ch (data_in_ch),
        .vld_in_ch  (vld_in_ch),
        .err_clr    (err_clr),
        .tx_data_ch (tx_data_ch),
        .tx_vld_ch  (tx_vld_ch),
        .crc_out    (crc_out),
        .frame_len  (frame_len),
        .crc_done   (crc_done),
        .crc_busy   (crc_busy),
        .ovf        (ovf),
        .err_onehot (err_onehot)
    );

    always #5 clk_out16x = ~clk_out16x;

    typedef struct {
        logic [7:0]  vld;
        logic [7:0]  data;
        logic        done;
        logic [15:0] crc;
        logic [15:0] len;
        int          run;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    bit   frame_bits[$];
    int   errors = 0;
    int   checks = 0;
    int   run    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: polynomial long division over the bit list
    function automatic logic [15:0] ref_crc();
        int unsigned r;
        r = 32'hFFFF;
        foreach (frame_bits[i]) begin
            r = r ^ (int'(frame_bits[i]) << 15);
            r = r << 1;
            if ((r & 32'h10000) != 0) r = r ^ 32'h11021;
        end
        return r[15:0];
    endfunction

    task automatic fill_random(input int n);
        frame_bits.delete();
        for (int i = 0; i < n; i++) frame_bits.push_back(1'($urandom));
    endtask

    task automatic fill_ascii(input string s);
        byte c;
        frame_bits.delete();
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            for (int b = 7; b >= 0; b--) frame_bits.push_back(c[b]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_out16x); #1;
            data_in_ch = 8'($urandom);
        end
    endtask

    task automatic send_frame(input int ch, input bit expect_out,
                              input int glitch_at, input int cut_at);
        logic [7:0]  m;
        logic [15:0] c;
        exp_t        x;
        int          n;
        m = 8'd1 << ch;
        n = frame_bits.size();
        for (int i = 0; i < n; i++) begin
            if (i == cut_at) return;
            @(posedge clk_out16x); #1;
            crc_valid = 1'b1;
            vld_in_ch = (glitch_at >= 0 && i >= glitch_at && i < glitch_at + 3) ? ~m : m;
            data_in_ch = 8'($urandom);
            data_in_ch[ch] = frame_bits[i];
            if (expect_out) begin
                x = '{vld: m, data: frame_bits[i] ? m : 8'h00, done: 1'b0,
                      crc: 16'h0, len: 16'h0, run: 0};
                sb.push_back(x);
            end
        end
        @(posedge clk_out16x); #1;
        crc_valid  = 1'b0;
        vld_in_ch  = 8'h00;
        data_in_ch = 8'($urandom);
        if (expect_out) begin
            c = ref_crc();
            for (int k = 15; k >= 0; k--) begin
                x = '{vld: m, data: c[k] ? m : 8'h00, done: (k == 0), crc: c,
                      len: (n > 65535) ? 16'hFFFF : 16'(n), run: n + 16};
                sb.push_back(x);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk_out16x);
        #1;
        chk("drain", sb.size(), 0);
    endtask

    task automatic pulse_clr();
        @(posedge clk_out16x); #1;
        err_clr = 1'b1;
        @(posedge clk_out16x); #1;
        err_clr = 1'b0;
    endtask

    always @(negedge clk_out16x) begin
        if (!rst_n) begin
            run = 0;
        end else if (tx_vld_ch != 8'h00) begin
            run++;
            if (sb.size() == 0) begin
                chk("unexpected_tx", tx_vld_ch, 0);
            end else begin
                e = sb.pop_front();
                chk("tx_vld", tx_vld_ch, e.vld);
                chk("tx_data", tx_data_ch, e.data);
                chk("crc_done", crc_done, e.done);
                if (e.done) begin
                    chk("run_len", run, e.run);
                    chk("crc_out", crc_out, e.crc);
                    chk("frame_len", frame_len, e.len);
                    run = 0;
                end
            end
        end else begin
            run = 0;
            chk("idle_out", {tx_data_ch, crc_done}, 0);
        end
    end

    initial begin
        #12;
        chk("rst_tx_vld", tx_vld_ch, 0);
        chk("rst_tx_data", tx_data_ch, 0);
        chk("rst_crc_out", crc_out, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_busy", {crc_busy, crc_done}, 0);
        chk("rst_flags", {ovf, err_onehot}, 0);
        @(negedge clk_out16x);
        rst_n = 1'b1;
        idle(3);

        fill_ascii("123456789");
        send_frame(2, 1'b1, -1, -1);
        drain();
        chk("check_crc_123456789", crc_out, 16'h29B1);
        chk("check_len_123456789", frame_len, 72);

        fill_ascii("\000");
        frame_bits.delete();
        repeat (8) frame_bits.push_back(1'b0);
        send_frame(7, 1'b1, -1, -1);
        drain();
        chk("check_crc_00", crc_out, 16'hE1F0);
        chk("check_len_00", frame_len, 8);

        fill_random(33);
        send_frame(1, 1'b1, -1, -1);
        idle(15);
        fill_random(21);
        send_frame(6, 1'b1, -1, -1);
        drain();
        chk("b2b_ovf", ovf, 0);

        fill_random(12);
        send_frame(3, 1'b1, -1, -1);
        idle(4);
        fill_random(30);
        send_frame(4, 1'b0, -1, -1);
        idle(3);
        drain();
        chk("overlap_ovf", ovf, 1);
        chk("overlap_err", err_onehot, 0);
        chk("overlap_busy", crc_busy, 0);
        pulse_clr();
        chk("ovf_cleared", ovf, 0);

        for (int i = 0; i < 6; i++) begin
            @(posedge clk_out16x); #1;
            crc_valid  = 1'b1;
            vld_in_ch  = 8'h05;
            data_in_ch = 8'($urandom);
            if (i == 3) chk("drop_busy", crc_busy, 1);
        end
        @(posedge clk_out16x); #1;
        crc_valid = 1'b0;
        vld_in_ch = 8'h00;
        idle(2);
        chk("multihot_err", err_onehot, 1);
        chk("multihot_nothing", sb.size(), 0);
        fill_random(20);
        send_frame(0, 1'b1, -1, -1);
        drain();
        chk("err_sticky", err_onehot, 1);
        pulse_clr();
        chk("err_cleared", err_onehot, 0);

        fill_random(24);
        send_frame(4, 1'b1, 6, -1);
        drain();
        chk("glitch_err", err_onehot, 1);
        pulse_clr();

        fill_random(128);
        send_frame(5, 1'b1, -1, 40);
        @(posedge clk_out16x);
        @(negedge clk_out16x); #1;
        rst_n      = 1'b0;
        crc_valid  = 1'b0;
        vld_in_ch  = 8'h00;
        #1;
        chk("midrst_tx", {tx_vld_ch, tx_data_ch}, 0);
        chk("midrst_crc_out", crc_out, 0);
        chk("midrst_len", frame_len, 0);
        chk("midrst_busy", {crc_busy, crc_done, ovf, err_onehot}, 0);
        chk("midrst_queue", sb.size(), 0);
        @(posedge clk_out16x);
        @(negedge clk_out16x);
        rst_n = 1'b1;
        idle(2);
        fill_random(50);
        send_frame(5, 1'b1, -1, -1);
        drain();

        for (int f = 0; f < 8; f++) begin
            fill_random((f == 0) ? 1 : int'($urandom_range(2, 40)));
            send_frame(int'($urandom_range(0, 7)), 1'b1, -1, -1);
            idle(int'($urandom_range(15, 20)));
        end
        drain();
        chk("final_flags", {ovf, err_onehot}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
